octopos_domain_busy_tracker: RTL

Per-domain activity tracker feeding the `domainN_busy` inputs of the Octopos reset module. It counts in-flight mailbox transactions for each of eight domains and holds busy high for a fixed guard window after the last one completes. The reset module therefore never sees a domain as idle while that domain still owns traffic. All outputs are registered, so the reset module samples glitch-free busy flags.

---
 rtl/octopos_reset_pkg.sv | 12 +
 rtl/octopos_busy_slot.sv | 66 ++++++
 rtl/octopos_domain_busy_tracker.sv | 38 +++
 3 files changed

// File: rtl/octopos_reset_pkg.sv
// octopos_reset_pkg: shared slot state type, default sizing and hold-timer width helper
package octopos_reset_pkg;
  typedef enum logic [1:0] {IDLE, ACTIVE, HOLD} slot_state_t;
  localparam int NUM_DOMAINS = 8;
  localparam int CNT_W = 4;
  localparam int HOLD_CYCLES = 16;
  function automatic int hold_w(input int hold_cycles);
    int w;
    w = $clog2(hold_cycles + 1);
    return (w < 1) ? 1 : w;
  endfunction
endpackage

// File: rtl/octopos_busy_slot.sv
// octopos_busy_slot: one domain's outstanding-transaction counter, guard timer and sticky error flags
module octopos_busy_slot
  import octopos_reset_pkg::*;
#(
  parameter int CNT_W       = octopos_reset_pkg::CNT_W,
  parameter int HOLD_CYCLES = octopos_reset_pkg::HOLD_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic stop,
  input  logic clear_err,
  output logic busy,
  output logic busy_next,
  output logic overflow,
  output logic underflow
);
  localparam int HW = hold_w(HOLD_CYCLES);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES > 0 ? HOLD_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  slot_state_t state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [HW-1:0] hold_cnt, hold_n;
  logic inc, dec, ovf_hit, unf_hit;
  // simultaneous start and end cancel: no count change and no error
  always_comb begin
    inc     = start & ~stop;
    dec     = stop & ~start;
    ovf_hit = inc && (cnt == CNT_MAX);
    unf_hit = dec && (cnt == '0);
    cnt_n   = (inc && !ovf_hit) ? cnt + 1'b1 : (dec && !unf_hit) ? cnt - 1'b1 : cnt;
    state_n = state;
    hold_n  = hold_cnt;
    case (state)
      IDLE:    if (inc) state_n = ACTIVE;
      ACTIVE:  if (cnt_n == '0) begin
        state_n = (HOLD_CYCLES > 0) ? HOLD : IDLE;
        hold_n  = HOLD_LOAD;
      end
      HOLD:    if (inc) begin
        state_n = ACTIVE;
        hold_n  = '0;
      end else if (hold_cnt == '0) state_n = IDLE;
      else hold_n = hold_cnt - 1'b1;
      default: state_n = IDLE;
    endcase
    busy_next = (state_n != IDLE);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      hold_cnt  <= '0;
      busy      <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      hold_cnt  <= hold_n;
      busy      <= busy_next;
      overflow  <= ovf_hit | (overflow & ~clear_err);
      underflow <= unf_hit | (underflow & ~clear_err);
    end
  end
endmodule

// File: rtl/octopos_domain_busy_tracker.sv
// octopos_domain_busy_tracker: per-domain busy flags with guard window for the Octopos reset module
module octopos_domain_busy_tracker
  import octopos_reset_pkg::*;
#(
  parameter int NUM_DOMAINS = octopos_reset_pkg::NUM_DOMAINS,
  parameter int CNT_W       = octopos_reset_pkg::CNT_W,
  parameter int HOLD_CYCLES = octopos_reset_pkg::HOLD_CYCLES
) (
  input  logic                   s00_axi_aclk,
  input  logic                   s00_axi_aresetn,
  input  logic [NUM_DOMAINS-1:0] txn_start,
  input  logic [NUM_DOMAINS-1:0] txn_end,
  input  logic                   clear_err,
  output logic [NUM_DOMAINS-1:0] domain_busy,
  output logic                   any_busy,
  output logic [NUM_DOMAINS-1:0] overflow,
  output logic [NUM_DOMAINS-1:0] underflow
);
  logic [NUM_DOMAINS-1:0] busy_next;
  for (genvar i = 0; i < NUM_DOMAINS; i++) begin : g_slot
    octopos_busy_slot #(.CNT_W(CNT_W), .HOLD_CYCLES(HOLD_CYCLES)) u_slot (
      .clk      (s00_axi_aclk),
      .rst_n    (s00_axi_aresetn),
      .start    (txn_start[i]),
      .stop     (txn_end[i]),
      .clear_err(clear_err),
      .busy     (domain_busy[i]),
      .busy_next(busy_next[i]),
      .overflow (overflow[i]),
      .underflow(underflow[i])
    );
  end
  // registered from next-state so it lines up with domain_busy
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) any_busy <= 1'b0;
    else any_busy <= |busy_next;
  end
endmodule
